bottleneck_const_func: RTL and testbench

//  Streaming MobileNetV3 bottleneck (expand -> ReLU6 -> depthwise -> project -> residual), hard-wired weights.

---
 rtl/bottleneck_const_func.sv | 153 +++++++++++++++
 tb/tb_bottleneck_const_func.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/bottleneck_const_func.sv
// Streaming MobileNetV3 bottleneck with channel-indexed constant weights:
// expand -> ReLU6 -> depthwise (centre tap) -> project -> residual, 4-cycle latency.
module bottleneck_const_func #(
  parameter int N               = 16,
  parameter int Q               = 8,
  parameter int IN_CHANNELS     = 16,
  parameter int OUT_CHANNELS    = 16,
  parameter int EXPAND_CHANNELS = 16,
  parameter int FEATURE_SIZE    = 112,
  parameter int KERNEL_SIZE     = 3,
  parameter int STRIDE          = 1,
  parameter int PADDING         = 1,
  parameter int FLUSH_CYCLES    = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic [N-1:0]                    data_in,
  input  logic [$clog2(IN_CHANNELS)-1:0]  channel_in,
  input  logic                            valid_in,
  output logic [N-1:0]                    data_out,
  output logic [$clog2(OUT_CHANNELS)-1:0] channel_out,
  output logic                            valid_out,
  output logic                            done
);

  localparam int CI_W   = $clog2(IN_CHANNELS);
  localparam int CO_W   = $clog2(OUT_CHANNELS);
  localparam int FRAME  = FEATURE_SIZE * FEATURE_SIZE * IN_CHANNELS;
  localparam int CNT_W  = $clog2(FRAME + 1);
  localparam int IDLE_W = $clog2(FLUSH_CYCLES + 1);
  localparam bit RES_EN = (STRIDE == 1) && (IN_CHANNELS == OUT_CHANNELS);

  localparam logic signed [N-1:0]   ONE    = N'(1 << Q);
  localparam logic signed [N-1:0]   HALF   = N'(1 << (Q - 1));
  localparam logic signed [N-1:0]   SIX    = N'(6 << Q);
  localparam logic signed [N-1:0]   MAX_N  = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0]   MIN_N  = {1'b1, {(N-1){1'b0}}};
  localparam logic signed [2*N-1:0] MAX_2N = {{(N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [2*N-1:0] MIN_2N = {{(N+1){1'b1}}, {(N-1){1'b0}}};

  // Layout-only parameters have no datapath effect; reject nonsensical values early.
  if ((KERNEL_SIZE % 2) == 0 || EXPAND_CHANNELS < 1 || PADDING < 0) begin : g_param_err
    $error("bottleneck_const_func: invalid layout parameters");
  end

  function automatic logic signed [N-1:0] sat_n(input logic signed [2*N-1:0] v);
    if (v > MAX_2N)      return MAX_N;
    else if (v < MIN_2N) return MIN_N;
    else                 return v[N-1:0];
  endfunction

  function automatic logic signed [N-1:0] mult(input logic signed [N-1:0] a,
                                               input logic signed [N-1:0] w);
    logic signed [2*N-1:0] prod;
    prod = (a * w) >>> Q;
    return sat_n(prod);
  endfunction

  function automatic logic signed [N-1:0] expand_w(input logic [CI_W-1:0] c);
    int w;
    w = (1 << Q) + (int'(c) << (Q - 4));
    return w[N-1:0];
  endfunction

  // Stage registers; x/channel ride alongside for the residual add.
  logic signed [N-1:0] x0_q, x1_q, x2_q, x3_q;
  logic [CI_W-1:0]     c0_q, c1_q, c2_q, c3_q;
  logic                v0_q, v1_q, v2_q, v3_q;
  logic signed [N-1:0] e_q, r_q, d_q;
  logic signed [N-1:0] e_d, r_d, d_d, p_d, y_d;

  logic [N-1:0]        data_out_q;
  logic [CO_W-1:0]     channel_out_q;
  logic                valid_out_q, done_q;

  logic [CNT_W-1:0]    in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic                done_d, accept, pipe_empty, frame_last, flush_hit;

  always_comb begin
    logic signed [2*N-1:0] p_w, x_w;
    e_d = mult(x0_q, expand_w(c0_q));
    if (e_q < 0)        r_d = '0;
    else if (e_q > SIX) r_d = SIX;
    else                r_d = e_q;
    d_d = mult(r_q, ONE);
    p_d = mult(d_q, HALF);
    p_w = p_d;
    x_w = x3_q;
    y_d = RES_EN ? sat_n(p_w + x_w) : p_d;
  end

  // Flush counts only idle enabled cycles after traffic has drained; an accept always wins.
  always_comb begin
    accept     = en && valid_in;
    pipe_empty = !(v0_q || v1_q || v2_q || v3_q);
    frame_last = v3_q && (out_cnt_q == CNT_W'(FRAME - 1));
    flush_hit  = !accept && (in_cnt_q != '0) && pipe_empty &&
                 (idle_cnt_q == IDLE_W'(FLUSH_CYCLES - 1));
    done_d     = frame_last || flush_hit;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    idle_cnt_d = '0;
    if (done_d) begin
      in_cnt_d  = accept ? CNT_W'(1) : '0;
      out_cnt_d = '0;
    end else begin
      if (accept) in_cnt_d  = in_cnt_q + CNT_W'(1);
      if (v3_q)   out_cnt_d = out_cnt_q + CNT_W'(1);
      if (!accept && (in_cnt_q != '0) && pipe_empty) idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      x0_q <= '0; x1_q <= '0; x2_q <= '0; x3_q <= '0;
      c0_q <= '0; c1_q <= '0; c2_q <= '0; c3_q <= '0;
      v0_q <= 1'b0; v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0;
      e_q <= '0; r_q <= '0; d_q <= '0;
      data_out_q    <= '0;
      channel_out_q <= '0;
      valid_out_q   <= 1'b0;
      done_q        <= 1'b0;
      in_cnt_q      <= '0;
      out_cnt_q     <= '0;
      idle_cnt_q    <= '0;
    end else if (en) begin
      x0_q <= data_in;  c0_q <= channel_in; v0_q <= valid_in;
      x1_q <= x0_q;     c1_q <= c0_q;       v1_q <= v0_q;  e_q <= e_d;
      x2_q <= x1_q;     c2_q <= c1_q;       v2_q <= v1_q;  r_q <= r_d;
      x3_q <= x2_q;     c3_q <= c2_q;       v3_q <= v2_q;  d_q <= d_d;
      if (v3_q) begin
        data_out_q    <= y_d;
        channel_out_q <= CO_W'(int'(c3_q) % OUT_CHANNELS);
      end
      valid_out_q <= v3_q;
      done_q      <= done_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
    end else begin
      valid_out_q <= 1'b0;
      done_q      <= 1'b0;
    end
  end

  assign data_out    = data_out_q;
  assign channel_out = channel_out_q;
  assign valid_out   = valid_out_q;
  assign done        = done_q;

endmodule

// File: tb/tb_bottleneck_const_func.sv
// Directed bench for bottleneck_const_func: scoreboard of hand-computed results,
// decoupled output monitor with latency, channel, contiguity and done-timing checks.
module tb_bottleneck_const_func;

  localparam int N       = 16;
  localparam int LAT     = 4;
  localparam int FLUSH   = 16;

  logic          clk = 1'b0;
  logic          rst, en, valid_in;
  logic [N-1:0]  data_in;
  logic [3:0]    channel_in;
  logic [N-1:0]  data_out;
  logic [3:0]    channel_out;
  logic          valid_out, done;

  int tests = 0, fails = 0;
  int cyc = 0, en_cyc = 0;
  int done_cnt = 0, done_cyc = 0, out_cnt = 0, last_out_cyc = 0, first_out_cyc = 0;
  bit mon_on = 1'b0, mark_first = 1'b0;

  logic [N-1:0] exp_q[$];
  logic [3:0]   expc_q[$];
  int           expt_q[$];

  bottleneck_const_func dut (
    .clk(clk), .rst(rst), .en(en),
    .data_in(data_in), .channel_in(channel_in), .valid_in(valid_in),
    .data_out(data_out), .channel_out(channel_out), .valid_out(valid_out), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (en) en_cyc <= en_cyc + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  always @(negedge clk) begin
    if (mon_on) begin
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid_out", 1, 0);
        end else begin
          logic [N-1:0] e;
          logic [3:0]   ec;
          int           et;
          e  = exp_q.pop_front();
          ec = expc_q.pop_front();
          et = expt_q.pop_front();
          check("data_out", int'(data_out), int'(e));
          check("channel_out", int'(channel_out), int'(ec));
          check("latency", en_cyc - et, LAT);
        end
        out_cnt++;
        last_out_cyc = cyc;
        if (mark_first) begin
          first_out_cyc = cyc;
          mark_first = 1'b0;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Drivers: called at a negedge, return at the next negedge.
  task automatic send(input logic [N-1:0] x, input logic [3:0] ch, input logic [N-1:0] y);
    en = 1'b1; valid_in = 1'b1; data_in = x; channel_in = ch;
    exp_q.push_back(y);
    expc_q.push_back(ch);
    expt_q.push_back(en_cyc + 1);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    en = 1'b1; valid_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic stall(input int n);
    en = 1'b0; valid_in = 1'b1; data_in = 16'h1234; channel_in = 4'd3;
    repeat (n) @(negedge clk);
    valid_in = 1'b0; en = 1'b1;
  endtask

  task automatic wait_done(input string name, input int bound);
    int start;
    int got;
    start = done_cnt;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done_cnt > start) break;
    end
    got = (done_cnt > start) ? 1 : 0;
    check({name, "_done_seen"}, got, 1);
    if (got == 1) check({name, "_done_gap"}, done_cyc - last_out_cyc, FLUSH);
    idle(8);
    check({name, "_done_single"}, done_cnt - start, 1);
    check({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int d0, o0;
    rst = 1'b0; en = 1'b0; valid_in = 1'b0; data_in = '0; channel_in = '0;
    repeat (3) @(negedge clk);
    check("reset_data_out", int'(data_out), 0);
    check("reset_channel_out", int'(channel_out), 0);
    check("reset_valid_out", int'(valid_out), 0);
    check("reset_done", int'(done), 0);
    rst = 1'b1;
    mon_on = 1'b1;

    // Disabled with valid_in high: nothing accepted, nothing emitted.
    en = 1'b0; valid_in = 1'b1; data_in = 16'h0800; channel_in = 4'd0;
    repeat (8) begin
      @(negedge clk);
      check("en0_valid_out", int'(valid_out), 0);
    end
    idle(24);
    check("no_done_before_input", done_cnt, 0);
    check("en0_no_outputs", out_cnt, 0);

    // Directed single vectors.
    send(16'h0800, 4'd0, 16'h0B00); idle(2);
    send(16'h0801, 4'd1, 16'h0B01); idle(1);
    send(16'h0100, 4'd0, 16'h0180); idle(3);
    send(16'hFF00, 4'd0, 16'hFF00); idle(1);
    send(16'h7F00, 4'd0, 16'h7FFF);
    idle(1);
    wait_done("directed", 60);

    // Mid-stream stall: outputs delayed, none lost or duplicated.
    o0 = out_cnt;
    for (int i = 0; i < 6; i++) send(16'h0800 + 16'(i), 4'(i), 16'h0B00 + 16'(i));
    stall(5);
    for (int i = 6; i < 12; i++) send(16'h0800 + 16'(i), 4'(i), 16'h0B00 + 16'(i));
    idle(1);
    wait_done("stall", 80);
    check("stall_out_count", out_cnt - o0, 12);

    // 148 back-to-back samples, channels wrapping 0..15.
    o0 = out_cnt;
    d0 = done_cnt;
    mark_first = 1'b1;
    for (int i = 0; i < 148; i++) send(16'h0800 + 16'(i), 4'(i % 16), 16'h0B00 + 16'(i));
    idle(1);
    check("stream_no_early_done", done_cnt - d0, 0);
    wait_done("stream", 80);
    check("stream_out_count", out_cnt - o0, 148);
    check("stream_contiguous", last_out_cyc - first_out_cyc, 147);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
